// File: rtl/noc_pkg.sv
// Shared port indices and XY dimension-order routing helpers for the mesh routers.
package noc_pkg;
  localparam int P_LOCAL    = 0;
  localparam int P_WEST     = 1;
  localparam int P_NORTH    = 2;
  localparam int P_EAST     = 3;
  localparam int P_SOUTH    = 4;
  localparam int NUM_PORTS  = 5;
  localparam int MAX_FLIT_W = 64;

  // Destination id lives in the top DEST_W bits of the flit.
  function automatic int unsigned dest_of(input logic [MAX_FLIT_W-1:0] flit,
                                          input int unsigned data_w,
                                          input int unsigned dest_w);
    logic [MAX_FLIT_W-1:0] sh;
    sh = flit >> (data_w - dest_w);
    return sh[31:0] & ((32'd1 << dest_w) - 32'd1);
  endfunction

  function automatic int unsigned col_of(input int unsigned id, input int unsigned mx);
    return id % mx;
  endfunction

  function automatic int unsigned row_of(input int unsigned id, input int unsigned mx);
    return id / mx;
  endfunction

  // One-hot output port; bit 5 flags a destination outside the mesh.
  function automatic logic [5:0] xy_route(input int unsigned own, input int unsigned dest,
                                          input int unsigned mx, input int unsigned my);
    logic [5:0] r;
    r = '0;
    if (dest >= mx * my)                          r[5]       = 1'b1;
    else if (col_of(dest, mx) > col_of(own, mx))  r[P_EAST]  = 1'b1;
    else if (col_of(dest, mx) < col_of(own, mx))  r[P_WEST]  = 1'b1;
    else if (row_of(dest, mx) > row_of(own, mx))  r[P_SOUTH] = 1'b1;
    else if (row_of(dest, mx) < row_of(own, mx))  r[P_NORTH] = 1'b1;
    else                                          r[P_LOCAL] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/noc_flit_fifo.sv
// Per-input flit FIFO: power-of-2 depth, wrapping pointers, occupancy count.
module noc_flit_fifo #(
  parameter int DATA_W     = 18,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_rd,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [AW:0]       r_count;
  logic              w_wr, w_rd;

  // Depth is a power of 2, so the count MSB alone means full.
  assign o_full  = r_count[AW];
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rptr];
  assign w_wr    = i_wr & ~o_full;
  assign w_rd    = i_rd & ~o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= i_data;
  end
endmodule

// File: rtl/mesh_router_buffered.sv
// 5-port buffered mesh router: input FIFOs, XY routing, per-output round-robin, drop counter.
module mesh_router_buffered
  import noc_pkg::*;
#(
  parameter int DATA_W     = 18,
  parameter int DEST_W     = 5,
  parameter int MESH_X     = 4,
  parameter int MESH_Y     = 4,
  parameter int ROUTER_ID  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_PORTS*DATA_W-1:0] i_data_in,
  input  logic [NUM_PORTS-1:0]        i_req_in,
  output logic [NUM_PORTS-1:0]        o_ack_out,
  output logic [NUM_PORTS*DATA_W-1:0] o_data_out,
  output logic [NUM_PORTS-1:0]        o_req_out,
  input  logic [NUM_PORTS-1:0]        i_ack_in,
  output logic [7:0]                  o_drop_count
);
  logic [NUM_PORTS-1:0][DATA_W-1:0] w_head;
  logic [NUM_PORTS-1:0][5:0]        w_route;
  logic [NUM_PORTS-1:0]             w_full, w_empty, w_push, w_pop, w_drop;
  logic [NUM_PORTS-1:0]             w_gnt [NUM_PORTS];
  logic [2:0]                       w_ndrop;
  logic [8:0]                       w_sum;
  logic                             r_ready;
  logic [7:0]                       r_drop;

  // ack_out stays low until the first edge after reset releases.
  assign o_ack_out    = {NUM_PORTS{r_ready}} & ~w_full;
  assign w_push       = i_req_in & o_ack_out;
  assign o_drop_count = r_drop;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
    noc_flit_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_wr    (w_push[p]),
      .i_data  (i_data_in[p*DATA_W +: DATA_W]),
      .i_rd    (w_pop[p]),
      .o_data  (w_head[p]),
      .o_full  (w_full[p]),
      .o_empty (w_empty[p])
    );
    assign w_route[p] = w_empty[p] ? 6'd0 :
      xy_route(ROUTER_ID, dest_of(MAX_FLIT_W'(w_head[p]), DATA_W, DEST_W), MESH_X, MESH_Y);
    assign w_drop[p]  = w_route[p][5];
  end

  // Routes are one-hot, so an input can win at most one output per cycle.
  always_comb begin
    w_pop   = w_drop;
    w_ndrop = '0;
    for (int o = 0; o < NUM_PORTS; o++) w_pop |= w_gnt[o];
    for (int p = 0; p < NUM_PORTS; p++) w_ndrop = w_ndrop + 3'(w_drop[p]);
  end

  assign w_sum = {1'b0, r_drop} + {6'd0, w_ndrop};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ready <= 1'b0;
      r_drop  <= '0;
    end else begin
      r_ready <= 1'b1;
      r_drop  <= w_sum[8] ? 8'hFF : w_sum[7:0];
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    logic                 w_free;
    logic [NUM_PORTS-1:0] w_g;
    logic [DATA_W-1:0]    w_sel;
    logic [2:0]           w_nxt, w_idx;
    logic                 r_req;
    logic [DATA_W-1:0]    r_data;
    logic [2:0]           r_ptr;

    assign w_free = ~r_req | i_ack_in[o];

    always_comb begin
      w_g   = '0;
      w_idx = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        w_idx = 3'((int'(r_ptr) + k) % NUM_PORTS);
        if (w_free && (w_g == '0) && w_route[w_idx][o]) w_g[w_idx] = 1'b1;
      end
    end

    always_comb begin
      w_sel = '0;
      w_nxt = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_g[p]) begin
          w_sel = w_head[p];
          w_nxt = 3'((p + 1) % NUM_PORTS);
        end
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_req  <= 1'b0;
        r_data <= '0;
        r_ptr  <= '0;
      end else if (w_free) begin
        r_req <= |w_g;
        if (|w_g) begin
          r_data <= w_sel;
          r_ptr  <= w_nxt;
        end
      end
    end

    assign w_gnt[o]                          = w_g;
    assign o_req_out[o]                      = r_req;
    assign o_data_out[o*DATA_W +: DATA_W]    = r_data;
  end
endmodule

// File: tb/tb_mesh_router_buffered.sv
// Bench for mesh_router_buffered at tile 5 of a 4x4 mesh: directed scenarios plus a random run against a queue model.
module tb_mesh_router_buffered;
  localparam int DW = 18;
  localparam int NP = 5;

  logic              i_clk, i_rst_n;
  logic [NP*DW-1:0]  i_data_in, o_data_out;
  logic [NP-1:0]     i_req_in, o_ack_out, o_req_out, i_ack_in;
  logic [7:0]        o_drop_count;

  int n_chk = 0, n_pass = 0;

  mesh_router_buffered #(.DATA_W(18), .DEST_W(5), .MESH_X(4), .MESH_Y(4),
                         .ROUTER_ID(5), .FIFO_DEPTH(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data_in(i_data_in), .i_req_in(i_req_in),
    .o_ack_out(o_ack_out), .o_data_out(o_data_out), .o_req_out(o_req_out),
    .i_ack_in(i_ack_in), .o_drop_count(o_drop_count));

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model: queues per input, one register per output, RR pointer per output.
  logic [DW-1:0] mq [NP][$];
  logic [DW-1:0] m_data [NP];
  logic [NP-1:0] m_req;
  int            m_ptr [NP];
  int            m_drop;
  bit            m_ready;
  logic [DW-1:0] rx_e [$];

  function automatic int route(input int d);
    if (d >= 16)    return 5;
    if (d % 4 > 1)  return 3;
    if (d % 4 < 1)  return 1;
    if (d / 4 > 1)  return 4;
    if (d / 4 < 1)  return 2;
    return 0;
  endfunction

  function automatic logic [DW-1:0] mkflit(input int d, input int pl);
    return {5'(d), 13'(pl)};
  endfunction

  function automatic logic [NP-1:0] m_ack();
    logic [NP-1:0] a;
    for (int p = 0; p < NP; p++) a[p] = m_ready && (mq[p].size() < 4);
    return a;
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    logic [NP-1:0] acc, pop;
    logic [DW-1:0] h;
    int drops, q;
    bit got;
    if (!i_rst_n) begin
      for (int p = 0; p < NP; p++) begin mq[p].delete(); m_data[p] = '0; m_ptr[p] = 0; end
      m_req = '0; m_drop = 0; m_ready = 0;
    end else begin
      acc = i_req_in & m_ack();
      pop = '0; drops = 0;
      for (int p = 0; p < NP; p++)
        if (mq[p].size() > 0) begin
          h = mq[p][0];
          if (route(int'(h[17:13])) == 5) begin pop[p] = 1; drops++; end
        end
      for (int o = 0; o < NP; o++)
        if (!m_req[o] || i_ack_in[o]) begin
          got = 0;
          for (int k = 0; k < NP; k++) begin
            q = (m_ptr[o] + k) % NP;
            if (!got && mq[q].size() > 0) begin
              h = mq[q][0];
              if (route(int'(h[17:13])) == o) begin
                got = 1; m_data[o] = h; pop[q] = 1; m_ptr[o] = (q + 1) % NP;
              end
            end
          end
          m_req[o] = got;
        end
      for (int p = 0; p < NP; p++) if (pop[p]) void'(mq[p].pop_front());
      for (int p = 0; p < NP; p++) if (acc[p]) mq[p].push_back(i_data_in[p*DW +: DW]);
      m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
      m_ready = 1;
    end
  end

  always @(posedge i_clk)
    if (i_rst_n && o_req_out[3] && i_ack_in[3]) rx_e.push_back(o_data_out[3*DW +: DW]);

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst_n = 0; i_req_in = 5'h1F; i_ack_in = 5'h1F;
    i_data_in = {$urandom, $urandom, $urandom};
    tick(); tick();
    n_chk++;
    if (o_req_out !== 5'h00 || o_ack_out !== 5'h00 || o_drop_count !== 8'd0 || o_data_out !== '0)
      $display("FAIL reset_hold: req_out=%h ack_out=%h drop=%0d, expected 0 0 0", o_req_out, o_ack_out, o_drop_count);
    else n_pass++;
    i_req_in = '0; i_rst_n = 1;
    #1;
    n_chk++;
    if (o_ack_out !== 5'h00) $display("FAIL reset_release_pre: ack_out=%h expected 00", o_ack_out);
    else n_pass++;
    tick();
    n_chk++;
    if (o_ack_out !== 5'h1F) $display("FAIL reset_release: ack_out=%h expected 1f", o_ack_out);
    else n_pass++;
  endtask

  task automatic test_route();
    int dests [5] = '{7, 13, 4, 1, 5};
    int ports [5] = '{3, 4, 1, 2, 0};
    logic [DW-1:0] f;
    for (int i = 0; i < 5; i++) begin
      f = mkflit(dests[i], 'h100 + i);
      i_data_in = '0; i_data_in[DW-1:0] = f; i_req_in = 5'h01;
      tick();
      i_req_in = '0;
      n_chk++;
      if (o_req_out !== 5'h00) $display("FAIL route_early dest=%0d: req_out=%b expected 00000", dests[i], o_req_out);
      else n_pass++;
      tick();
      n_chk++;
      if (o_req_out !== 5'(1 << ports[i]) || o_data_out[ports[i]*DW +: DW] !== f)
        $display("FAIL route dest=%0d: req_out=%b data=%h, expected %b data=%h", dests[i],
                 o_req_out, o_data_out[ports[i]*DW +: DW], 5'(1 << ports[i]), f);
      else n_pass++;
      tick();
    end
  endtask

  task automatic rr_pair(input string nm, input logic [DW-1:0] first, input logic [DW-1:0] second,
                         input logic [DW-1:0] fw, input logic [DW-1:0] fn);
    i_data_in = '0; i_data_in[1*DW +: DW] = fw; i_data_in[2*DW +: DW] = fn; i_req_in = 5'b00110;
    tick();
    i_req_in = '0;
    tick();
    n_chk++;
    if (o_req_out[3] !== 1'b1 || o_data_out[3*DW +: DW] !== first)
      $display("FAIL %s_first: req=%b data=%h expected 1 %h", nm, o_req_out[3], o_data_out[3*DW +: DW], first);
    else n_pass++;
    tick();
    n_chk++;
    if (o_req_out[3] !== 1'b1 || o_data_out[3*DW +: DW] !== second)
      $display("FAIL %s_second: req=%b data=%h expected 1 %h", nm, o_req_out[3], o_data_out[3*DW +: DW], second);
    else n_pass++;
    tick();
  endtask

  task automatic test_rr();
    logic [DW-1:0] w, n;
    w = mkflit(6, 'hA1); n = mkflit(6, 'hB2);
    rr_pair("rr1", w, n, w, n);
    // West alone leaves the east pointer at north.
    i_data_in = '0; i_data_in[1*DW +: DW] = mkflit(6, 'hC3); i_req_in = 5'b00010;
    tick(); i_req_in = '0; tick(); tick();
    w = mkflit(6, 'hA4); n = mkflit(6, 'hB5);
    rr_pair("rr2", n, w, w, n);
  endtask

  task automatic fill_blocked(output int acc);
    int k = 1;
    acc = 0;
    i_ack_in = 5'h17;
    for (int c = 0; c < 12; c++) begin
      logic a;
      i_data_in = '0; i_data_in[DW-1:0] = mkflit(6, k); i_req_in = 5'h01;
      a = o_ack_out[0];
      tick();
      if (a) begin k++; acc++; end
    end
    i_req_in = '0;
  endtask

  task automatic test_backpressure();
    int acc, k;
    rx_e.delete();
    fill_blocked(acc);
    n_chk++;
    if (acc !== 5 || o_ack_out[0] !== 1'b0 || o_data_out[3*DW +: DW] !== mkflit(6, 1))
      $display("FAIL bp_fill: accepted=%0d ack_local=%b head=%h expected 5 0 %h", acc, o_ack_out[0],
               o_data_out[3*DW +: DW], mkflit(6, 1));
    else n_pass++;
    i_ack_in = 5'h1F;
    k = 6;
    for (int c = 0; c < 40 && k <= 9; c++) begin
      logic a;
      i_data_in = '0; i_data_in[DW-1:0] = mkflit(6, k); i_req_in = 5'h01;
      a = o_ack_out[0];
      tick();
      if (a) k++;
    end
    i_req_in = '0;
    repeat (8) tick();
    n_chk++;
    if (k !== 10 || rx_e.size() !== 9) $display("FAIL bp_count: sent_to=%0d received=%0d expected 10 9", k, rx_e.size());
    else n_pass++;
    for (int i = 0; i < 9 && i < rx_e.size(); i++) begin
      n_chk++;
      if (rx_e[i] !== mkflit(6, i + 1)) $display("FAIL bp_order[%0d]: got %h expected %h", i, rx_e[i], mkflit(6, i + 1));
      else n_pass++;
    end
  endtask

  task automatic test_drop();
    int k = 0;
    i_data_in = '0; i_data_in[DW-1:0] = mkflit(20, 'h55); i_req_in = 5'h01;
    tick();
    i_req_in = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++;
      if (o_req_out !== 5'h00) $display("FAIL drop_noemit: req_out=%b expected 00000", o_req_out);
      else n_pass++;
    end
    n_chk++;
    if (o_drop_count !== 8'd1) $display("FAIL drop_one: drop=%0d expected 1", o_drop_count);
    else n_pass++;
    for (int c = 0; c < 400 && k < 299; c++) begin
      logic a;
      i_data_in = '0; i_data_in[DW-1:0] = mkflit(20 + (k % 12), k); i_req_in = 5'h01;
      a = o_ack_out[0];
      tick();
      if (a) k++;
    end
    i_req_in = '0;
    repeat (6) tick();
    n_chk++;
    if (k !== 299 || o_drop_count !== 8'd255) $display("FAIL drop_sat: sent=%0d drop=%0d expected 299 255", k, o_drop_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int acc;
    rx_e.delete();
    fill_blocked(acc);
    n_chk++;
    if (o_req_out[3] !== 1'b1) $display("FAIL rmid_pre: req_east=%b expected 1", o_req_out[3]);
    else n_pass++;
    #2 i_rst_n = 0;
    #1;
    n_chk++;
    if (o_req_out !== 5'h00 || o_ack_out !== 5'h00) $display("FAIL rmid_async: req_out=%b ack_out=%b expected 0 0", o_req_out, o_ack_out);
    else n_pass++;
    @(negedge i_clk);
    i_rst_n = 1; i_ack_in = 5'h1F;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_chk++;
      if (o_req_out !== 5'h00 || o_ack_out !== 5'h1F)
        $display("FAIL rmid_stale: req_out=%b ack_out=%b expected 00000 11111", o_req_out, o_ack_out);
      else n_pass++;
    end
    n_chk++;
    if (rx_e.size() !== 0) $display("FAIL rmid_rx: received=%0d expected 0", rx_e.size());
    else n_pass++;
  endtask

  task automatic test_random();
    int nbad = 0;
    i_req_in = '0; i_data_in = '0;
    for (int c = 0; c < 400; c++) begin
      logic [NP-1:0] acc;
      bit ok;
      for (int p = 0; p < NP; p++)
        if (!i_req_in[p]) begin
          i_req_in[p] = ($urandom_range(0, 1) == 1);
          i_data_in[p*DW +: DW] = mkflit($urandom_range(0, 19), $urandom);
        end
      for (int o = 0; o < NP; o++) i_ack_in[o] = ($urandom_range(0, 3) != 0);
      acc = i_req_in & o_ack_out;
      tick();
      i_req_in = i_req_in & ~acc;
      ok = (o_req_out === m_req) && (o_ack_out === m_ack()) && (o_drop_count === 8'(m_drop));
      for (int o = 0; o < NP; o++) if (m_req[o] && o_data_out[o*DW +: DW] !== m_data[o]) ok = 0;
      n_chk++;
      if (!ok) begin
        nbad++;
        if (nbad < 10)
          $display("FAIL random cyc %0d: req_out=%b ack_out=%b drop=%0d, expected %b %b %0d",
                   c, o_req_out, o_ack_out, o_drop_count, m_req, m_ack(), m_drop);
      end else n_pass++;
    end
    i_req_in = '0; i_ack_in = 5'h1F;
    repeat (10) tick();
  endtask

  initial begin
    i_rst_n = 0; i_req_in = '0; i_ack_in = 5'h1F; i_data_in = '0;
    @(negedge i_clk);
    test_reset();
    test_route();
    test_rr();
    test_backpressure();
    test_drop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
